// File: rtl/alu_pkg.sv
// Shared command encodings and defaults for the ALU issue stage.
package alu_pkg;

  localparam int unsigned DEFAULT_DATA_WIDTH = 32;
  localparam int unsigned DEFAULT_CMD_WIDTH  = 3;
  // Result buffer entries; also the issue credit limit.
  localparam int unsigned RES_DEPTH          = 3;

  typedef enum logic [DEFAULT_CMD_WIDTH-1:0] {
    AND_CMD = 3'd0,
    OR_CMD  = 3'd1,
    XOR_CMD = 3'd2,
    SLT_CMD = 3'd3,
    ADD_CMD = 3'd4,
    SUB_CMD = 3'd5,
    NOP_CMD = 3'd7
  } alu_cmd_e;

  // Commands 6/7 make the ALU hold its output; only 0..5 produce a result.
  function automatic logic is_legal_cmd(input logic [DEFAULT_CMD_WIDTH-1:0] cmd);
    return cmd <= SUB_CMD;
  endfunction

endpackage

// File: rtl/alu_dispatch_if.sv
// Op request and result return channels of the ALU issue stage.
interface alu_dispatch_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned CMD_WIDTH  = 3,
  parameter int unsigned TAG_WIDTH  = 4
);
  logic                  op_valid;
  logic                  op_ready;
  logic [DATA_WIDTH-1:0] op_in1;
  logic [DATA_WIDTH-1:0] op_in2;
  logic [CMD_WIDTH-1:0]  op_cmd;
  logic                  op_sign;
  logic [TAG_WIDTH-1:0]  op_tag;

  logic                  res_valid;
  logic                  res_ready;
  logic [DATA_WIDTH-1:0] res_data;
  logic [TAG_WIDTH-1:0]  res_tag;
  logic                  res_err;

  // Upstream requester / result consumer.
  modport master (
    output op_valid, op_in1, op_in2, op_cmd, op_sign, op_tag, res_ready,
    input  op_ready, res_valid, res_data, res_tag, res_err
  );

  // The dispatch block.
  modport slave (
    input  op_valid, op_in1, op_in2, op_cmd, op_sign, op_tag, res_ready,
    output op_ready, res_valid, res_data, res_tag, res_err
  );
endinterface

// File: rtl/alu_sync_fifo.sv
// Synchronous FIFO with combinational head read; any DEPTH >= 1.
module alu_sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic                         pop,
  input  logic [WIDTH-1:0]             din,
  output logic [WIDTH-1:0]             dout,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);
  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;
  // Empty reads as zero so an idle head never exposes stale data.
  assign dout  = empty ? '0 : mem[rd_q];

  // Pointer wrap and occupancy update; push is ignored when full.
  always_comb begin
    do_push = push && !full;
    do_pop  = pop && !empty;
    wr_d    = wr_q;
    rd_d    = rd_q;
    count_d = count_q;
    if (do_push) wr_d = (wr_q == AW'(DEPTH-1)) ? '0 : wr_q + 1'b1;
    if (do_pop)  rd_d = (rd_q == AW'(DEPTH-1)) ? '0 : rd_q + 1'b1;
    if (do_push && !do_pop)      count_d = count_q + 1'b1;
    else if (!do_push && do_pop) count_d = count_q - 1'b1;
  end

  // Pointer and count state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else begin
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      count_q <= count_d;
    end
  end

  // Storage write.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_q] <= din;
  end
endmodule

// File: rtl/alu_dispatch.sv
// Issue stage for the handshake-less arith_log ALU: buffers ops, issues one per
// cycle under a result-buffer credit, and returns tagged results.
module alu_dispatch
  import alu_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int unsigned CMD_WIDTH  = DEFAULT_CMD_WIDTH,
  parameter int unsigned TAG_WIDTH  = 4,
  parameter int unsigned DEPTH      = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  alu_dispatch_if.slave         io,
  output logic [DATA_WIDTH-1:0] alu_in1,
  output logic [DATA_WIDTH-1:0] alu_in2,
  output logic [CMD_WIDTH-1:0]  alu_cmd,
  output logic                  alu_sign,
  input  logic [DATA_WIDTH-1:0] alu_result
);
  localparam int unsigned OP_W  = 2*DATA_WIDTH + CMD_WIDTH + 1 + TAG_WIDTH;
  localparam int unsigned RES_W = DATA_WIDTH + TAG_WIDTH + 1;
  localparam int unsigned RB_CW = $clog2(RES_DEPTH+1);

  logic [OP_W-1:0]              op_din, op_dout;
  logic                         op_full, op_empty;
  logic [$clog2(DEPTH+1)-1:0]   op_count_unused;

  logic [DATA_WIDTH-1:0]        h_in1, h_in2;
  logic [CMD_WIDTH-1:0]         h_cmd;
  logic                         h_sign;
  logic [TAG_WIDTH-1:0]         h_tag;
  logic                         issue, head_legal;

  logic                         inflight_q, inflight_d;
  logic [TAG_WIDTH-1:0]         infl_tag_q, infl_tag_d;
  logic                         infl_err_q, infl_err_d;

  logic [RES_W-1:0]             rb_din, rb_dout;
  logic [DATA_WIDTH-1:0]        rb_wdata;
  logic                         rb_full_unused, rb_empty;
  logic [RB_CW-1:0]             rb_count;

  assign op_din      = {io.op_in1, io.op_in2, io.op_cmd, io.op_sign, io.op_tag};
  assign io.op_ready = !op_full;

  alu_sync_fifo #(.WIDTH(OP_W), .DEPTH(DEPTH)) u_op_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (io.op_valid),
    .pop   (issue),
    .din   (op_din),
    .dout  (op_dout),
    .full  (op_full),
    .empty (op_empty),
    .count (op_count_unused)
  );

  // Issue decision and ALU drive. The credit uses only registered occupancy,
  // so res_ready never reaches alu_* or op_ready combinationally.
  always_comb begin
    {h_in1, h_in2, h_cmd, h_sign, h_tag} = op_dout;
    issue      = !op_empty && ((32'(rb_count) + 32'(inflight_q)) < RES_DEPTH);
    head_legal = is_legal_cmd(h_cmd);
    alu_in1    = '0;
    alu_in2    = '0;
    alu_cmd    = CMD_WIDTH'(NOP_CMD);
    alu_sign   = 1'b0;
    if (issue && head_legal) begin
      alu_in1  = h_in1;
      alu_in2  = h_in2;
      alu_cmd  = h_cmd;
      alu_sign = h_sign;
    end
    inflight_d = issue;
    infl_tag_d = issue ? h_tag : '0;
    infl_err_d = issue && !head_legal;
  end

  // Tracks the op whose result appears at the ALU output next cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inflight_q <= 1'b0;
      infl_tag_q <= '0;
      infl_err_q <= 1'b0;
    end else begin
      inflight_q <= inflight_d;
      infl_tag_q <= infl_tag_d;
      infl_err_q <= infl_err_d;
    end
  end

  // Result capture; illegal ops report zero data with the error flag.
  always_comb begin
    rb_wdata = infl_err_q ? '0 : alu_result;
    rb_din   = {rb_wdata, infl_tag_q, infl_err_q};
  end

  alu_sync_fifo #(.WIDTH(RES_W), .DEPTH(RES_DEPTH)) u_res_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (inflight_q),
    .pop   (io.res_ready),
    .din   (rb_din),
    .dout  (rb_dout),
    .full  (rb_full_unused),
    .empty (rb_empty),
    .count (rb_count)
  );

  assign io.res_valid = !rb_empty;
  assign {io.res_data, io.res_tag, io.res_err} = rb_dout;
endmodule

// File: tb/tb_alu_dispatch.sv
// Bench for alu_dispatch with a behavioural stand-in for the arith_log ALU.
module tb_alu_dispatch;
  import alu_pkg::*;

  localparam int unsigned DW = 32;
  localparam int unsigned CW = 3;
  localparam int unsigned TW = 4;
  localparam int unsigned DEPTH = 4;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [TW-1:0] tag;
    logic          err;
  } res_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  alu_dispatch_if #(.DATA_WIDTH(DW), .CMD_WIDTH(CW), .TAG_WIDTH(TW)) io ();

  logic [DW-1:0] alu_in1, alu_in2, alu_result;
  logic [CW-1:0] alu_cmd;
  logic          alu_sign;
  logic          alu_rst_n;
  assign alu_rst_n = ~rst;

  alu_dispatch #(.DATA_WIDTH(DW), .CMD_WIDTH(CW), .TAG_WIDTH(TW), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .io         (io),
    .alu_in1    (alu_in1),
    .alu_in2    (alu_in2),
    .alu_cmd    (alu_cmd),
    .alu_sign   (alu_sign),
    .alu_result (alu_result)
  );

  // arith_log stand-in: registered output, holds on cmd 6/7, SLT is in1 > in2.
  always_ff @(posedge clk or negedge alu_rst_n) begin
    if (!alu_rst_n) alu_result <= '0;
    else begin
      case (alu_cmd)
        3'd0: alu_result <= alu_in1 & alu_in2;
        3'd1: alu_result <= alu_in1 | alu_in2;
        3'd2: alu_result <= alu_in1 ^ alu_in2;
        3'd3: alu_result <= alu_sign ? DW'($signed(alu_in1) > $signed(alu_in2))
                                     : DW'(alu_in1 > alu_in2);
        3'd4: alu_result <= alu_in1 + alu_in2;
        3'd5: alu_result <= alu_in1 - alu_in2;
        default: alu_result <= alu_result;
      endcase
    end
  end

  int          n_checks = 0;
  int          n_pass   = 0;
  int          cyc      = 0;
  logic        acc;
  res_t        exp_q[$];
  int          res_cycles[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Expected result of one accepted op, from the command table.
  function automatic res_t ref_result(input logic [31:0] a, input logic [31:0] b,
                                      input logic [2:0] cmd, input logic sg,
                                      input logic [3:0] tag);
    res_t r;
    r.tag = tag;
    r.err = 1'b0;
    case (cmd)
      3'd0: r.data = a & b;
      3'd1: r.data = a | b;
      3'd2: r.data = a ^ b;
      3'd3: begin
        if (sg) r.data = (int'(a) > int'(b)) ? 32'd1 : 32'd0;
        else    r.data = (a > b) ? 32'd1 : 32'd0;
      end
      3'd4: r.data = a + b;
      3'd5: r.data = a - b;
      default: begin
        r.data = '0;
        r.err  = 1'b1;
      end
    endcase
    return r;
  endfunction

  // One clock: observe both handshakes at the negedge, then advance past the edge.
  task automatic tick();
    res_t e;
    @(negedge clk);
    acc = 1'b0;
    if (!rst) begin
      if (io.op_valid && io.op_ready) begin
        exp_q.push_back(ref_result(io.op_in1, io.op_in2, io.op_cmd, io.op_sign, io.op_tag));
        acc = 1'b1;
      end
      if (io.res_valid && io.res_ready) begin
        res_cycles.push_back(cyc);
        if (exp_q.size() == 0) check("unexpected_result", 64'd1, 64'd0);
        else begin
          e = exp_q.pop_front();
          check("res_data", io.res_data, e.data);
          check("res_tag",  io.res_tag,  e.tag);
          check("res_err",  io.res_err,  e.err);
        end
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic offer(input logic [31:0] a, input logic [31:0] b, input logic [2:0] cmd,
                       input logic sg, input logic [3:0] tag);
    io.op_valid = 1'b1;
    io.op_in1   = a;
    io.op_in2   = b;
    io.op_cmd   = cmd;
    io.op_sign  = sg;
    io.op_tag   = tag;
  endtask

  task automatic offer_rand(input logic [3:0] tag);
    logic [2:0] legal [4];
    legal = '{3'd0, 3'd1, 3'd2, 3'd5};
    offer($urandom, $urandom, legal[$urandom_range(3)], 1'($urandom_range(1)), tag);
  endtask

  task automatic push_op(input logic [31:0] a, input logic [31:0] b, input logic [2:0] cmd,
                         input logic sg, input logic [3:0] tag);
    offer(a, b, cmd, sg, tag);
    tick();
    for (int i = 0; i < 30 && !acc; i++) tick();
    check("op_accepted", acc, 1'b1);
    io.op_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 80 && exp_q.size() != 0; i++) tick();
    check("drain_empty", exp_q.size(), 0);
    repeat (3) tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int          accepted;
    int          start;
    logic [31:0] sum;

    io.op_valid = 1'b0; io.op_in1 = '0; io.op_in2 = '0; io.op_cmd = '0;
    io.op_sign = 1'b0;  io.op_tag = '0; io.res_ready = 1'b1;

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    check("rst_op_ready",  io.op_ready,  1'b1);
    check("rst_res_valid", io.res_valid, 1'b0);
    check("rst_res_data",  io.res_data,  32'd0);
    check("rst_res_tag",   io.res_tag,   4'd0);
    check("rst_res_err",   io.res_err,   1'b0);
    check("rst_alu_cmd",   alu_cmd,      3'd7);
    check("rst_alu_in1",   alu_in1,      32'd0);
    check("rst_alu_in2",   alu_in2,      32'd0);
    check("rst_alu_sign",  alu_sign,     1'b0);
    rst = 1'b0;
    tick();

    // Single ADD: issue one cycle after the push edge, result two cycles later
    offer(32'd5, 32'd7, 3'd4, 1'b0, 4'd3);
    tick();
    check("single_acc", acc, 1'b1);
    io.op_valid = 1'b0;
    check("single_issue_cmd", alu_cmd, 3'd4);
    check("single_issue_in1", alu_in1, 32'd5);
    check("single_issue_in2", alu_in2, 32'd7);
    check("single_valid_n1", io.res_valid, 1'b0);
    tick();
    check("single_valid_n2", io.res_valid, 1'b0);
    tick();
    check("single_valid_n3", io.res_valid, 1'b1);
    check("single_data", io.res_data, 32'd12);
    check("single_tag",  io.res_tag,  4'd3);
    drain();

    // Stream of 8 back-to-back ops: accepted one per cycle, results on consecutive cycles
    res_cycles.delete();
    start = cyc;
    for (int i = 0; i < 8; i++) begin
      offer_rand(4'(i));
      tick();
      check("stream_acc", acc, 1'b1);
    end
    io.op_valid = 1'b0;
    check("stream_push_cycles", cyc - start, 8);
    drain();
    check("stream_count", res_cycles.size(), 8);
    if (res_cycles.size() == 8) check("stream_consecutive", res_cycles[7] - res_cycles[0], 7);

    // SLT signed and unsigned on the same operands
    push_op(32'hFFFF_FFFF, 32'd1, 3'd3, 1'b1, 4'd10);
    push_op(32'hFFFF_FFFF, 32'd1, 3'd3, 1'b0, 4'd11);
    drain();

    // Back-pressure: 3 results buffered/in flight plus DEPTH queued, then stall
    res_cycles.delete();
    io.res_ready = 1'b0;
    accepted = 0;
    offer_rand(4'd0);
    for (int i = 0; i < 20; i++) begin
      tick();
      if (acc) begin
        accepted++;
        if (accepted < 10) offer_rand(4'(accepted));
        else io.op_valid = 1'b0;
      end
    end
    check("bp_accepted", accepted, 3 + DEPTH);
    check("bp_op_ready", io.op_ready, 1'b0);
    check("bp_res_valid", io.res_valid, 1'b1);
    io.res_ready = 1'b1;
    for (int i = 0; i < 40 && accepted < 10; i++) begin
      tick();
      if (acc) begin
        accepted++;
        if (accepted < 10) offer_rand(4'(accepted));
        else io.op_valid = 1'b0;
      end
    end
    io.op_valid = 1'b0;
    check("bp_total_accepted", accepted, 10);
    drain();
    check("bp_result_count", res_cycles.size(), 10);

    // Illegal cmd between two ADDs
    offer(32'd100, 32'd23, 3'd4, 1'b0, 4'd1); tick(); check("ill_acc0", acc, 1'b1);
    offer(32'd9,   32'd9,  3'd6, 1'b0, 4'd2); tick(); check("ill_acc1", acc, 1'b1);
    offer(32'd40,  32'd2,  3'd4, 1'b0, 4'd3); tick(); check("ill_acc2", acc, 1'b1);
    io.op_valid = 1'b0;
    drain();

    // ALU output holds across an illegal op, which is driven as NOP
    sum = $urandom;
    push_op(sum, 32'd1, 3'd4, 1'b0, 4'd4);
    drain();
    offer(32'hDEAD_BEEF, 32'h1234_5678, 3'd6, 1'b1, 4'd5);
    tick();
    io.op_valid = 1'b0;
    check("nop_issue_cmd", alu_cmd, 3'd7);
    check("nop_issue_in1", alu_in1, 32'd0);
    check("nop_issue_sign", alu_sign, 1'b0);
    drain();
    check("alu_hold", alu_result, sum + 32'd1);

    // Reset with ops queued and one in flight drops everything
    for (int i = 0; i < 4; i++) begin
      offer_rand(4'(i + 8));
      tick();
    end
    io.op_valid = 1'b0;
    rst = 1'b1;
    exp_q.delete();
    tick();
    check("mid_rst_res_valid", io.res_valid, 1'b0);
    check("mid_rst_op_ready",  io.op_ready,  1'b1);
    check("mid_rst_alu_cmd",   alu_cmd,      3'd7);
    rst = 1'b0;
    tick();
    res_cycles.delete();
    push_op(32'd20, 32'd22, 3'd4, 1'b0, 4'd7);
    drain();
    check("post_rst_count", res_cycles.size(), 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
